// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares one 4-digit multiplexed 7-segment display between two BCD sources.
//   Round-robin arbitration with a minimum hold time per owner so a value
//   stays readable. Idle output is all-0xF digits (shown blank by the driver).
//
// Parameters
//   HOLD_CYCLES  minimum clk_i cycles a granted owner keeps the display (>=1)
//
// Ports
//   clk_i     in   system clock
//   rst_i     in   synchronous reset, active-high
//   req_i     in   [1:0] per-requester level request
//   bcd0_i    in   [15:0] requester 0 value, [3:0] = units
//   bcd1_i    in   [15:0] requester 1 value
//   grant_o   out  [1:0] one-hot current owner, 2'b00 = idle
//   bcd_o     out  [15:0] registered display value
//   switch_o  out  one-cycle pulse after grant_o changes
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 27000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [15:0] bcd0_i,
  input  logic [15:0] bcd1_i,
  output logic [1:0]  grant_o,
  output logic [15:0] bcd_o,
  output logic        switch_o
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          switch_q, switch_d;

  logic          grant_en;
  logic          grant_idx;
  logic          own;
  logic          own_req;
  logic          oth_req;
  logic          expired;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      bcd_q    <= '1;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      bcd_q    <= bcd_d;
      switch_q <= switch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    grant_en  = 1'b0;
    grant_idx = 1'b0;
    own       = (state_q == OWN1);
    own_req   = req_i[own];
    oth_req   = req_i[~own];
    expired   = (cnt_q == '0);

    unique case (state_q)
      IDLE: begin
        if (&req_i) begin
          grant_en  = 1'b1;
          grant_idx = ~last_q;
        end else if (req_i[0]) begin
          grant_en  = 1'b1;
          grant_idx = 1'b0;
        end else if (req_i[1]) begin
          grant_en  = 1'b1;
          grant_idx = 1'b1;
        end
      end
      OWN0, OWN1: begin
        // Owner release wins over the hold counter; otherwise the other
        // requester waits for expiry. Expiry with no contender re-grants
        // the owner, which reloads the counter without a switch pulse.
        if (!own_req) begin
          if (oth_req) begin
            grant_en  = 1'b1;
            grant_idx = ~own;
          end else begin
            state_d = IDLE;
          end
        end else if (expired) begin
          grant_en  = 1'b1;
          grant_idx = oth_req ? ~own : own;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      state_d = grant_idx ? OWN1 : OWN0;
      cnt_d   = HOLD_LOAD;
      last_d  = grant_idx;
    end

    unique case (state_d)
      OWN0:    bcd_d = bcd0_i;
      OWN1:    bcd_d = bcd1_i;
      default: bcd_d = '1;
    endcase

    switch_d = (state_d != state_q);
  end

  // Output logic
  always_comb begin
    unique case (state_q)
      OWN0:    grant_o = 2'b01;
      OWN1:    grant_o = 2'b10;
      default: grant_o = 2'b00;
    endcase
    bcd_o    = bcd_q;
    switch_o = switch_q;
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
//   Scenario tasks drive per-cycle stimulus rows, push the expected outputs
//   onto a scoreboard queue, and pop/compare one cycle later.
module tb_display_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] bcd0;
  logic [15:0] bcd1;
  logic [1:0]  grant;
  logic [15:0] bcd;
  logic        sw;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        r;
    logic [1:0]  rq;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [1:0]  eg;
    logic [15:0] eb;
    logic        es;
  } row_t;

  typedef struct {
    logic [1:0]  g;
    logic [15:0] b;
    logic        s;
  } exp_t;

  exp_t sb[$];

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .bcd0_i   (bcd0),
    .bcd1_i   (bcd1),
    .grant_o  (grant),
    .bcd_o    (bcd),
    .switch_o (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input logic r, input logic [1:0] rq,
                              input logic [15:0] b0, input logic [15:0] b1,
                              input logic [1:0] eg, input logic [15:0] eb,
                              input logic es);
    row_t x;
    x.r = r; x.rq = rq; x.b0 = b0; x.b1 = b1;
    x.eg = eg; x.eb = eb; x.es = es;
    return x;
  endfunction

  task automatic drive(input row_t x);
    exp_t e;
    rst  = x.r;
    req  = x.rq;
    bcd0 = x.b0;
    bcd1 = x.b1;
    e.g = x.eg; e.b = x.eb; e.s = x.es;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 2'b11, 16'h1111, 16'h2222, 2'b00, 16'hFFFF, 0));
    rows.push_back(mk(1, 2'b11, 16'h1111, 16'h2222, 2'b00, 16'hFFFF, 0));
    rows.push_back(mk(0, 2'b00, 16'h1111, 16'h2222, 2'b00, 16'hFFFF, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, bcd, sw} !== {e.g, e.b, e.s}) begin
        errors++;
        $display("FAIL reset[%0d]: got grant=%b bcd=%h sw=%b, want grant=%b bcd=%h sw=%b",
                 i, grant, bcd, sw, e.g, e.b, e.s);
      end
    end
  endtask

  task automatic test_single_owner();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234, 1));
    for (int k = 0; k < 20; k++)
      rows.push_back(mk(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234, 0));
    rows.push_back(mk(0, 2'b01, 16'h1235, 16'h0000, 2'b01, 16'h1235, 0));
    rows.push_back(mk(0, 2'b00, 16'h1235, 16'h0000, 2'b00, 16'hFFFF, 1));
    rows.push_back(mk(0, 2'b00, 16'h1235, 16'h0000, 2'b00, 16'hFFFF, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, bcd, sw} !== {e.g, e.b, e.s}) begin
        errors++;
        $display("FAIL single_owner[%0d]: got grant=%b bcd=%h sw=%b, want grant=%b bcd=%h sw=%b",
                 i, grant, bcd, sw, e.g, e.b, e.s);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 2'b00, 16'hAAAA, 16'h5555, 2'b00, 16'hFFFF, 0));
    rows.push_back(mk(0, 2'b11, 16'hAAAA, 16'h5555, 2'b01, 16'hAAAA, 1));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(0, 2'b11, 16'hAAAA, 16'h5555, 2'b01, 16'hAAAA, 0));
    rows.push_back(mk(0, 2'b11, 16'hAAAA, 16'h5555, 2'b10, 16'h5555, 1));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(0, 2'b11, 16'hAAAA, 16'h5555, 2'b10, 16'h5555, 0));
    rows.push_back(mk(0, 2'b11, 16'hAAAA, 16'h5555, 2'b01, 16'hAAAA, 1));
    rows.push_back(mk(0, 2'b11, 16'hAAAA, 16'h5555, 2'b01, 16'hAAAA, 0));
    rows.push_back(mk(0, 2'b00, 16'hAAAA, 16'h5555, 2'b00, 16'hFFFF, 1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, bcd, sw} !== {e.g, e.b, e.s}) begin
        errors++;
        $display("FAIL round_robin[%0d]: got grant=%b bcd=%h sw=%b, want grant=%b bcd=%h sw=%b",
                 i, grant, bcd, sw, e.g, e.b, e.s);
      end
    end
  endtask

  // Starts idle with last owner 0, so the later tie goes to requester 1.
  task automatic test_early_release();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 2'b01, 16'h4321, 16'h9999, 2'b01, 16'h4321, 1));
    rows.push_back(mk(0, 2'b01, 16'h4321, 16'h9999, 2'b01, 16'h4321, 0));
    rows.push_back(mk(0, 2'b00, 16'h4321, 16'h9999, 2'b00, 16'hFFFF, 1));
    rows.push_back(mk(0, 2'b11, 16'h4321, 16'h9999, 2'b10, 16'h9999, 1));
    rows.push_back(mk(0, 2'b00, 16'h4321, 16'h9999, 2'b00, 16'hFFFF, 1));
    rows.push_back(mk(0, 2'b00, 16'h4321, 16'h9999, 2'b00, 16'hFFFF, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, bcd, sw} !== {e.g, e.b, e.s}) begin
        errors++;
        $display("FAIL early_release[%0d]: got grant=%b bcd=%h sw=%b, want grant=%b bcd=%h sw=%b",
                 i, grant, bcd, sw, e.g, e.b, e.s);
      end
    end
  endtask

  task automatic test_handover();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 2'b01, 16'h1111, 16'h2222, 2'b01, 16'h1111, 1));
    rows.push_back(mk(0, 2'b11, 16'h1111, 16'h2222, 2'b01, 16'h1111, 0));
    rows.push_back(mk(0, 2'b10, 16'h1111, 16'h2222, 2'b10, 16'h2222, 1));
    rows.push_back(mk(0, 2'b10, 16'h1111, 16'h2223, 2'b10, 16'h2223, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, bcd, sw} !== {e.g, e.b, e.s}) begin
        errors++;
        $display("FAIL handover[%0d]: got grant=%b bcd=%h sw=%b, want grant=%b bcd=%h sw=%b",
                 i, grant, bcd, sw, e.g, e.b, e.s);
      end
    end
  endtask

  // Entered while owner 1 holds the display with its counter non-zero.
  task automatic test_mid_hold_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 2'b11, 16'h7777, 16'h8888, 2'b00, 16'hFFFF, 0));
    rows.push_back(mk(0, 2'b11, 16'h7777, 16'h8888, 2'b01, 16'h7777, 1));
    rows.push_back(mk(0, 2'b11, 16'h7777, 16'h8888, 2'b01, 16'h7777, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if ({grant, bcd, sw} !== {e.g, e.b, e.s}) begin
        errors++;
        $display("FAIL mid_hold_reset[%0d]: got grant=%b bcd=%h sw=%b, want grant=%b bcd=%h sw=%b",
                 i, grant, bcd, sw, e.g, e.b, e.s);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b00;
    bcd0 = '0;
    bcd1 = '0;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_early_release();
    test_handover();
    test_mid_hold_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
